tsp_city_loader: RTL

Byte-stream loader that receives a framed city list and drives the coordinate arrays into the tsp core. Sits between a byte source (UART RX or host bridge, valid/ready) and the core's xs/ys inputs. Decodes the frame, checks a checksum, and commits the new city set atomically. Emits a one-cycle load_done pulse so the top level can restart the solver.

---
 rtl/tsp_city_loader_if.sv | 12 +
 rtl/tsp_city_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tsp_city_loader_if.sv
// Byte-stream valid/ready channel feeding tsp_city_loader.
// The source drives data/valid; the loader answers with ready.
interface tsp_city_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tsp_city_loader.sv
// Framed city-list loader: A5, n, (x,y)*n, csum -> staged, checked, committed atomically.
// Optional inter-byte timeout enabled by defining TSP_LOADER_TIMEOUT_EN.
module tsp_city_loader #(
  parameter int N_CITIES    = 64,
  parameter int COORD_W     = 8,
  parameter int TIMEOUT_CYC = 50000000,
  localparam int CNT_W      = $clog2(N_CITIES + 1),
  localparam int IDX_W      = $clog2(N_CITIES)
) (
  input  logic                         clk,
  input  logic                         rst,
  tsp_city_loader_if.slave             i_stream,
  output logic [N_CITIES*COORD_W-1:0]  o_xs,
  output logic [N_CITIES*COORD_W-1:0]  o_ys,
  output logic [CNT_W-1:0]             o_n_cities,
  output logic                         o_load_done,
  output logic                         o_busy,
  output logic                         o_err
);

  if (COORD_W != 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("tsp_city_loader: COORD_W must be 8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_X, S_Y, S_CSUM, S_COMMIT
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  state_t                      r_state;
  state_t                      w_next;
  logic                        w_ready;
  logic                        w_busy;
  logic                        w_accept;
  logic                        w_count_bad;
  logic                        w_last;
  logic                        w_timeout;

  logic [CNT_W-1:0]            r_cnt;
  logic [IDX_W-1:0]            r_idx;
  logic [7:0]                  r_sum;
  logic [COORD_W-1:0]          r_stage_x [N_CITIES];
  logic [COORD_W-1:0]          r_stage_y [N_CITIES];
  logic [N_CITIES*COORD_W-1:0] r_xs;
  logic [N_CITIES*COORD_W-1:0] r_ys;
  logic [CNT_W-1:0]            r_n_cities;
  logic                        r_load_done;
  logic                        r_err;

  assign w_accept    = i_stream.in_valid && w_ready;
  assign w_count_bad = (i_stream.in_data == 8'd0) || (int'(i_stream.in_data) > N_CITIES);
  assign w_last      = (int'(r_idx) == int'(r_cnt) - 1);

`ifdef TSP_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts idle cycles inside a frame; COMMIT never waits on the stream.
  assign w_timeout = w_busy && (r_state != S_COMMIT) && !w_accept &&
                     (int'(r_to_cnt) == TIMEOUT_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_accept || !w_busy || (r_state == S_COMMIT) || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && i_stream.in_data == HEADER) w_next = S_COUNT;
      S_COUNT:  if (w_accept) w_next = w_count_bad ? S_IDLE : S_X;
      S_X:      if (w_accept) w_next = S_Y;
      S_Y:      if (w_accept) w_next = w_last ? S_CSUM : S_X;
      S_CSUM:   if (w_accept) w_next = (i_stream.in_data == r_sum) ? S_COMMIT : S_IDLE;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    if (!rst && r_state != S_COMMIT) w_ready = 1'b1;
    if (r_state != S_IDLE)           w_busy  = 1'b1;
  end

  // Frame decode into staging, then whole-set commit from COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_n_cities  <= '0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < N_CITIES; i++) begin
        r_stage_x[i] <= '0;
        r_stage_y[i] <= '0;
      end
    end else begin
      r_load_done <= 1'b0;
      if (w_timeout) r_err <= 1'b1;
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (i_stream.in_data == HEADER) r_err <= 1'b0;
          end
          S_COUNT: begin
            if (w_count_bad) begin
              r_err <= 1'b1;
            end else begin
              r_cnt <= i_stream.in_data[CNT_W-1:0];
              r_idx <= '0;
              r_sum <= i_stream.in_data;
            end
          end
          S_X: begin
            r_stage_x[r_idx] <= i_stream.in_data;
            r_sum            <= r_sum + i_stream.in_data;
          end
          S_Y: begin
            r_stage_y[r_idx] <= i_stream.in_data;
            r_sum            <= r_sum + i_stream.in_data;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
          S_CSUM: begin
            if (i_stream.in_data != r_sum) r_err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (r_state == S_COMMIT) begin
        for (int i = 0; i < N_CITIES; i++) begin
          r_xs[i*COORD_W +: COORD_W] <= (i < int'(r_cnt)) ? r_stage_x[i] : '0;
          r_ys[i*COORD_W +: COORD_W] <= (i < int'(r_cnt)) ? r_stage_y[i] : '0;
        end
        r_n_cities  <= r_cnt;
        r_load_done <= 1'b1;
      end
    end
  end

  assign i_stream.in_ready = w_ready;
  assign o_busy            = w_busy;
  assign o_xs              = r_xs;
  assign o_ys              = r_ys;
  assign o_n_cities        = r_n_cities;
  assign o_load_done       = r_load_done;
  assign o_err             = r_err;

endmodule
